// File: rtl/tft_fb_pkg.sv
// Shared types and constants for the TFT framebuffer: RGB565 pixel layout,
// default display geometry and the bring-up colour-bar palette.
package tft_fb_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam int DISP_W   = 320;
    localparam int DISP_H   = 240;
    localparam int NUM_BARS = 8;

    localparam rgb565_t BAR_COLORS [NUM_BARS] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

endpackage

// File: rtl/tft_fb_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port,
// read-before-write on a same-address collision.
module tft_fb_ram #(
    parameter int DEPTH  = 4800,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/tft_framebuffer.sv
// Pull-style pixel source for the TFT driver: nearest-neighbour upscale of a
// low-resolution RGB565 image, with an optional colour-bar test pattern.
module tft_framebuffer
    import tft_fb_pkg::*;
#(
    parameter int SRC_W  = 80,
    parameter int SRC_H  = 60,
    parameter int SCALE  = 4,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fb_clk,
    output logic [15:0]       fb_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic              pattern_en,
    input  logic              frame_sync,
    output logic              frame_wrap
);

    localparam int SX_W   = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int PX_W   = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int PY_W   = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int LINE_W = SRC_W * SCALE;
    localparam int BAR_W  = LINE_W / NUM_BARS;
    localparam int BX_W   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [ADDR_W:0] NPIX = (ADDR_W+1)'(SRC_W * SRC_H);

    logic              fb_clk_q, req, last_pix;
    logic [SX_W-1:0]   sx, cur_sx, nxt_sx, sy, cur_sy, nxt_sy;
    logic [PX_W-1:0]   px, cur_px, nxt_px;
    logic [PY_W-1:0]   py, cur_py, nxt_py;
    logic [ADDR_W-1:0] row_base, cur_row, nxt_row;
    logic [BX_W-1:0]   bx, cur_bx, nxt_bx;
    logic [2:0]        bar, cur_bar, nxt_bar;

    logic              vld_p0, vld_p1, pat_p0, pat_p1;
    logic [2:0]        bar_p0, bar_p1;
    logic [ADDR_W-1:0] rd_addr_p0;
    logic [15:0]       ram_q;
    logic              wr_ok;

    assign req   = fb_clk & ~fb_clk_q;
    assign wr_ok = wr_en && ({1'b0, wr_addr} < NPIX);

    // frame_sync zeroes the position the request reads from as well as the stored one
    always_comb begin
        cur_sx  = frame_sync ? '0 : sx;
        cur_px  = frame_sync ? '0 : px;
        cur_sy  = frame_sync ? '0 : sy;
        cur_py  = frame_sync ? '0 : py;
        cur_row = frame_sync ? '0 : row_base;
        cur_bx  = frame_sync ? '0 : bx;
        cur_bar = frame_sync ? '0 : bar;
        nxt_sx  = cur_sx;
        nxt_px  = cur_px;
        nxt_sy  = cur_sy;
        nxt_py  = cur_py;
        nxt_row = cur_row;
        nxt_bx  = cur_bx;
        nxt_bar = cur_bar;
        last_pix = 1'b0;
        if (req) begin
            if (cur_bx == BX_W'(BAR_W - 1)) begin
                nxt_bx  = '0;
                nxt_bar = cur_bar + 3'd1;
            end else begin
                nxt_bx = cur_bx + 1'b1;
            end
            if (cur_sx == SX_W'(SCALE - 1)) begin
                nxt_sx = '0;
                if (cur_px == PX_W'(SRC_W - 1)) begin
                    nxt_px  = '0;
                    nxt_bx  = '0;
                    nxt_bar = '0;
                    if (cur_sy == SX_W'(SCALE - 1)) begin
                        nxt_sy = '0;
                        if (cur_py == PY_W'(SRC_H - 1)) begin
                            nxt_py   = '0;
                            nxt_row  = '0;
                            last_pix = 1'b1;
                        end else begin
                            nxt_py  = cur_py + 1'b1;
                            nxt_row = cur_row + ADDR_W'(SRC_W);
                        end
                    end else begin
                        nxt_sy = cur_sy + 1'b1;
                    end
                end else begin
                    nxt_px = cur_px + 1'b1;
                end
            end else begin
                nxt_sx = cur_sx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_clk_q   <= 1'b0;
            sx         <= '0;
            px         <= '0;
            sy         <= '0;
            py         <= '0;
            row_base   <= '0;
            bx         <= '0;
            bar        <= '0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            frame_wrap <= 1'b0;
            fb_data    <= '0;
        end else begin
            fb_clk_q   <= fb_clk;
            sx         <= nxt_sx;
            px         <= nxt_px;
            sy         <= nxt_sy;
            py         <= nxt_py;
            row_base   <= nxt_row;
            bx         <= nxt_bx;
            bar        <= nxt_bar;
            vld_p0     <= req;
            vld_p1     <= vld_p0;
            frame_wrap <= last_pix;
            // p1 -> output: RAM word or bar colour lands on the driver
            if (vld_p1) fb_data <= pat_p1 ? BAR_COLORS[bar_p1] : ram_q;
        end
    end

    // request -> p0: latch address and pattern selection; p0 -> p1: RAM read
    always_ff @(posedge clk) begin
        if (req) begin
            rd_addr_p0 <= cur_row + ADDR_W'(cur_px);
            pat_p0     <= pattern_en;
            bar_p0     <= cur_bar;
        end
        pat_p1 <= pat_p0;
        bar_p1 <= bar_p0;
    end

    tft_fb_ram #(
        .DEPTH  (SRC_W * SRC_H),
        .ADDR_W (ADDR_W),
        .DATA_W (16)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (vld_p0),
        .rd_addr (rd_addr_p0),
        .rd_data (ram_q)
    );

endmodule
